// File: rtl/gemm_issue_seq_if.sv
// gemm_issue_seq_if: bundle of the GEMM issue sequencer's handshake and bus signals.
// slave is the sequencer side; master is the side that drives the FU, scratchpad,
// array and writeback inputs.
interface gemm_issue_seq_if #(
  parameter int unsigned MAT_W = 4,
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             push_valid;
  logic             push_ready;
  logic             push_new_weight;
  logic [MAT_W-1:0] push_rd;
  logic [MAT_W-1:0] push_rs1;
  logic [MAT_W-1:0] push_rs2;
  logic [MAT_W-1:0] push_rs3;
  logic [CntW-1:0]  fifo_count;
  logic             sp_req_valid;
  logic             sp_req_ready;
  logic [1:0]       sp_req_kind;
  logic [MAT_W-1:0] sp_req_mat;
  logic             array_start;
  logic             array_done;
  logic             wb_valid;
  logic             wb_ready;
  logic [MAT_W-1:0] wb_rd;
  logic             busy;

  modport slave (
    input  push_valid, push_new_weight, push_rd, push_rs1, push_rs2, push_rs3,
    input  sp_req_ready, array_done, wb_ready,
    output push_ready, fifo_count, sp_req_valid, sp_req_kind, sp_req_mat,
    output array_start, wb_valid, wb_rd, busy
  );

  modport master (
    output push_valid, push_new_weight, push_rd, push_rs1, push_rs2, push_rs3,
    output sp_req_ready, array_done, wb_ready,
    input  push_ready, fifo_count, sp_req_valid, sp_req_kind, sp_req_mat,
    input  array_start, wb_valid, wb_rd, busy
  );
endinterface

// File: rtl/gemm_issue_seq.sv
// gemm_issue_seq: buffers GEMM instruction entries in a small FIFO and steps each one
// through weight/input/psum scratchpad loads, an array compute and a result writeback.
// Optional macro GEMM_WEIGHT_SKIP_EN: when defined, the weight load is skipped for
// entries whose new_weight flag is clear (resident weights are reused).
module gemm_issue_seq #(
  parameter int unsigned MAT_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  gemm_issue_seq_if.slave io_bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic             new_weight;
    logic [MAT_W-1:0] rd;
    logic [MAT_W-1:0] rs3;
    logic [MAT_W-1:0] rs2;
    logic [MAT_W-1:0] rs1;
  } entry_t;

  typedef enum logic [2:0] {
    StIdle, StLdW, StLdI, StLdP, StStart, StWait, StWb
  } state_e;

  entry_t           r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic [MAT_W-1:0] r_cur_rd;
  logic [MAT_W-1:0] r_cur_rs1;
  logic [MAT_W-1:0] r_cur_rs2;
  logic [MAT_W-1:0] r_cur_rs3;
  state_e           r_state;
  state_e           w_state_d;

  logic   w_full;
  logic   w_push;
  logic   w_pop;
  logic   w_need_w;
  entry_t w_push_ent;
  entry_t w_head;

  assign w_full     = (r_count == CntW'(DEPTH));
  assign w_push     = io_bus.push_valid && !w_full;
  // Only one entry in flight: the head is taken only while the sequencer is idle.
  assign w_pop      = (r_state == StIdle) && (r_count != '0);
  assign w_head     = r_mem[r_rptr];
  assign w_push_ent = '{new_weight: io_bus.push_new_weight, rd: io_bus.push_rd,
                        rs3: io_bus.push_rs3, rs2: io_bus.push_rs2, rs1: io_bus.push_rs1};

`ifdef GEMM_WEIGHT_SKIP_EN
  assign w_need_w = w_head.new_weight;
`else
  // new_weight is kept in the FIFO but every entry reloads weights.
  logic w_unused_nw;
  assign w_unused_nw = w_head.new_weight;
  assign w_need_w    = 1'b1;
`endif

  // FIFO data storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_ent;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Current-entry register, loaded on pop and held for the whole entry lifetime.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cur_rd  <= '0;
      r_cur_rs1 <= '0;
      r_cur_rs2 <= '0;
      r_cur_rs3 <= '0;
    end else if (w_pop) begin
      r_cur_rd  <= w_head.rd;
      r_cur_rs1 <= w_head.rs1;
      r_cur_rs2 <= w_head.rs2;
      r_cur_rs3 <= w_head.rs3;
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state and request outputs; outputs depend only on registered state, so
  // kind/mat/rd are stable for as long as a request is held.
  always_comb begin
    w_state_d           = r_state;
    io_bus.sp_req_valid = 1'b0;
    io_bus.sp_req_kind  = 2'd0;
    io_bus.sp_req_mat   = '0;
    io_bus.array_start  = 1'b0;
    io_bus.wb_valid     = 1'b0;
    io_bus.wb_rd        = '0;
    unique case (r_state)
      StIdle: begin
        if (w_pop) w_state_d = w_need_w ? StLdW : StLdI;
      end
      StLdW: begin
        io_bus.sp_req_valid = 1'b1;
        io_bus.sp_req_kind  = 2'd0;
        io_bus.sp_req_mat   = r_cur_rs2;
        if (io_bus.sp_req_ready) w_state_d = StLdI;
      end
      StLdI: begin
        io_bus.sp_req_valid = 1'b1;
        io_bus.sp_req_kind  = 2'd1;
        io_bus.sp_req_mat   = r_cur_rs1;
        if (io_bus.sp_req_ready) w_state_d = StLdP;
      end
      StLdP: begin
        io_bus.sp_req_valid = 1'b1;
        io_bus.sp_req_kind  = 2'd2;
        io_bus.sp_req_mat   = r_cur_rs3;
        if (io_bus.sp_req_ready) w_state_d = StStart;
      end
      StStart: begin
        io_bus.array_start = 1'b1;
        w_state_d          = StWait;
      end
      StWait: begin
        // array_done is only honoured here; pulses in other states are dropped.
        if (io_bus.array_done) w_state_d = StWb;
      end
      StWb: begin
        io_bus.wb_valid = 1'b1;
        io_bus.wb_rd    = r_cur_rd;
        if (io_bus.wb_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign io_bus.fifo_count = r_count;
  assign io_bus.push_ready = !w_full;
  assign io_bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_gemm_issue_seq.sv
// tb_gemm_issue_seq: directed bench for gemm_issue_seq with a transaction-level model.
// Each accepted push appends the operations that entry must produce (loads, start,
// writeback) to an expected stream; a negedge monitor checks every handshake against it.
module tb_gemm_issue_seq;
  localparam int unsigned MAT_W = 4;
  localparam int unsigned DEPTH = 4;
`ifdef GEMM_WEIGHT_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  typedef struct {
    int unsigned kind;  // 0..2 load kind, 3 array start, 4 writeback
    int unsigned val;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gemm_issue_seq_if #(.MAT_W(MAT_W), .DEPTH(DEPTH)) bus ();

  gemm_issue_seq #(.MAT_W(MAT_W), .DEPTH(DEPTH)) dut (
    .CLK    (clk),
    .RST    (rst),
    .io_bus (bus)
  );

  op_t         exp_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          auto_done = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Advance one clock; array_done answers an array_start one cycle later when enabled.
  task automatic tick();
    logic s;
    s = bus.array_start;
    @(posedge clk);
    #1;
    bus.array_done = auto_done && s;
  endtask

  task automatic model_push(input int unsigned nw, input int unsigned rd, input int unsigned rs1,
                            input int unsigned rs2, input int unsigned rs3);
    if (nw != 0 || !SkipEn) exp_q.push_back('{kind: 0, val: rs2});
    exp_q.push_back('{kind: 1, val: rs1});
    exp_q.push_back('{kind: 2, val: rs3});
    exp_q.push_back('{kind: 3, val: 0});
    exp_q.push_back('{kind: 4, val: rd});
  endtask

  task automatic push(input int unsigned nw, input int unsigned rd, input int unsigned rs1,
                      input int unsigned rs2, input int unsigned rs3, input bit acc);
    bus.push_valid      = 1'b1;
    bus.push_new_weight = (nw != 0);
    bus.push_rd         = 4'(rd);
    bus.push_rs1        = 4'(rs1);
    bus.push_rs2        = 4'(rs2);
    bus.push_rs3        = 4'(rs3);
    check("push_ready", 32'(bus.push_ready), 32'(acc));
    if (acc) model_push(nw, 4'(rd), 4'(rs1), 4'(rs2), 4'(rs3));
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check({name, "_ops_left"}, 32'(exp_q.size()), 0);
    tick();
    check({name, "_busy_after"}, 32'(bus.busy), 0);
    check({name, "_count_after"}, 32'(bus.fifo_count), 0);
  endtask

  // Monitor: every handshake/start must match the head of the expected stream, and
  // stalled requests must hold their payload.
  initial begin : monitor
    logic       ps, pw;
    logic [1:0] pk;
    logic [3:0] pm, prd;
    op_t        o;
    ps = 1'b0; pw = 1'b0; pk = '0; pm = '0; prd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ps = 1'b0;
        pw = 1'b0;
      end else begin
        if (ps) begin
          check("sp_hold_valid", 32'(bus.sp_req_valid), 1);
          check("sp_hold_kind", 32'(bus.sp_req_kind), 32'(pk));
          check("sp_hold_mat", 32'(bus.sp_req_mat), 32'(pm));
        end
        if (pw) begin
          check("wb_hold_valid", 32'(bus.wb_valid), 1);
          check("wb_hold_rd", 32'(bus.wb_rd), 32'(prd));
        end
        if (bus.array_start || (bus.sp_req_valid && bus.sp_req_ready) ||
            (bus.wb_valid && bus.wb_ready)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 32'({bus.sp_req_valid, bus.array_start, bus.wb_valid}), 0);
          end else begin
            o = exp_q.pop_front();
            if (o.kind < 3) begin
              check("sp_req_valid", 32'(bus.sp_req_valid), 1);
              check("sp_req_kind", 32'(bus.sp_req_kind), o.kind);
              check("sp_req_mat", 32'(bus.sp_req_mat), o.val);
            end else if (o.kind == 3) begin
              check("array_start", 32'(bus.array_start), 1);
            end else begin
              check("wb_valid", 32'(bus.wb_valid), 1);
              check("wb_rd", 32'(bus.wb_rd), o.val);
            end
          end
        end
        ps  = bus.sp_req_valid && !bus.sp_req_ready;
        pk  = bus.sp_req_kind;
        pm  = bus.sp_req_mat;
        pw  = bus.wb_valid && !bus.wb_ready;
        prd = bus.wb_rd;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin : main
    bus.push_valid      = 1'b0;
    bus.push_new_weight = 1'b0;
    bus.push_rd         = '0;
    bus.push_rs1        = '0;
    bus.push_rs2        = '0;
    bus.push_rs3        = '0;
    bus.sp_req_ready    = 1'b1;
    bus.array_done      = 1'b0;
    bus.wb_ready        = 1'b1;

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    check("rst_fifo_count", 32'(bus.fifo_count), 0);
    check("rst_push_ready", 32'(bus.push_ready), 1);
    check("rst_sp_req_valid", 32'(bus.sp_req_valid), 0);
    check("rst_sp_req_kind", 32'(bus.sp_req_kind), 0);
    check("rst_sp_req_mat", 32'(bus.sp_req_mat), 0);
    check("rst_array_start", 32'(bus.array_start), 0);
    check("rst_wb_valid", 32'(bus.wb_valid), 0);
    check("rst_wb_rd", 32'(bus.wb_rd), 0);
    check("rst_busy", 32'(bus.busy), 0);

    // Single entry with weight load, minimum latency
    push(1, 3, 1, 2, 4, 1'b1);
    check("t1_count_queued", 32'(bus.fifo_count), 1);
    check("t1_busy_before_pop", 32'(bus.busy), 0);
    tick();
    check("t1_c1_valid", 32'(bus.sp_req_valid), 1);
    check("t1_c1_kind", 32'(bus.sp_req_kind), 0);
    check("t1_c1_mat", 32'(bus.sp_req_mat), 2);
    check("t1_c1_count", 32'(bus.fifo_count), 0);
    tick();
    check("t1_c2_kind", 32'(bus.sp_req_kind), 1);
    check("t1_c2_mat", 32'(bus.sp_req_mat), 1);
    tick();
    check("t1_c3_kind", 32'(bus.sp_req_kind), 2);
    check("t1_c3_mat", 32'(bus.sp_req_mat), 4);
    tick();
    check("t1_c4_start", 32'(bus.array_start), 1);
    check("t1_c4_sp_valid", 32'(bus.sp_req_valid), 0);
    tick();
    check("t1_c5_start_low", 32'(bus.array_start), 0);
    check("t1_c5_wb_low", 32'(bus.wb_valid), 0);
    tick();
    check("t1_c6_wb_valid", 32'(bus.wb_valid), 1);
    check("t1_c6_wb_rd", 32'(bus.wb_rd), 3);
    tick();
    check("t1_busy_after_wb", 32'(bus.busy), 0);
    check("t1_wb_low_after", 32'(bus.wb_valid), 0);

    // new_weight = 0: weight load depends on the skip option
    push(0, 5, 6, 7, 8, 1'b1);
    tick();
    check("t2_first_valid", 32'(bus.sp_req_valid), 1);
    check("t2_first_kind", 32'(bus.sp_req_kind), SkipEn ? 1 : 0);
    check("t2_first_mat", 32'(bus.sp_req_mat), SkipEn ? 6 : 7);
    drain("t2");

    // Fill the FIFO behind a stalled scratchpad
    bus.sp_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(32'(i % 2), 32'(i + 1), 32'(i + 5), 32'(i + 9), 32'(i + 12), 1'b1);
    end
    check("t3_count_full", 32'(bus.fifo_count), 4);
    check("t3_busy", 32'(bus.busy), 1);
    push(1, 15, 15, 15, 15, 1'b0);
    check("t3_count_after_refused", 32'(bus.fifo_count), 4);
    bus.sp_req_ready = 1'b1;
    drain("t3");

    // Stall in LD_I for three cycles
    bus.sp_req_ready = 1'b0;
    push(0, 9, 10, 11, 12, 1'b1);
    tick();
    if (bus.sp_req_kind == 2'd0) begin
      bus.sp_req_ready = 1'b1;
      tick();
      bus.sp_req_ready = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      check("t4_ldi_valid", 32'(bus.sp_req_valid), 1);
      check("t4_ldi_kind", 32'(bus.sp_req_kind), 1);
      check("t4_ldi_mat", 32'(bus.sp_req_mat), 10);
      tick();
    end
    bus.sp_req_ready = 1'b1;
    tick();
    check("t4_ldp_kind", 32'(bus.sp_req_kind), 2);
    check("t4_ldp_mat", 32'(bus.sp_req_mat), 12);
    drain("t4");

    // array_done outside WAIT is dropped
    auto_done        = 1'b0;
    bus.sp_req_ready = 1'b0;
    push(1, 13, 14, 15, 1, 1'b1);
    tick();
    for (int n = 0; n < 4 && bus.sp_req_kind != 2'd2; n++) begin
      bus.sp_req_ready = 1'b1;
      tick();
      bus.sp_req_ready = 1'b0;
    end
    check("t5_in_ldp", 32'(bus.sp_req_kind), 2);
    bus.array_done = 1'b1;
    tick();
    check("t5_still_ldp", 32'(bus.sp_req_valid), 1);
    bus.sp_req_ready = 1'b1;
    tick();
    check("t5_start", 32'(bus.array_start), 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t5_wait_no_wb", 32'(bus.wb_valid), 0);
      check("t5_wait_busy", 32'(bus.busy), 1);
      tick();
    end
    bus.array_done = 1'b1;
    tick();
    check("t5_wb_valid", 32'(bus.wb_valid), 1);
    check("t5_wb_rd", 32'(bus.wb_rd), 13);
    auto_done = 1'b1;
    drain("t5");

    // Reset during WAIT with two entries queued
    auto_done = 1'b0;
    push(1, 1, 2, 3, 4, 1'b1);
    push(0, 5, 6, 7, 8, 1'b1);
    push(1, 9, 10, 11, 12, 1'b1);
    for (int n = 0; n < 10 && !bus.array_start; n++) tick();
    check("t6_start_seen", 32'(bus.array_start), 1);
    tick();
    check("t6_wait_count", 32'(bus.fifo_count), 2);
    check("t6_wait_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_count", 32'(bus.fifo_count), 0);
    check("t6_wb_valid", 32'(bus.wb_valid), 0);
    check("t6_push_ready", 32'(bus.push_ready), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_quiet_sp", 32'(bus.sp_req_valid), 0);
      check("t6_quiet_wb", 32'(bus.wb_valid), 0);
    end
    auto_done = 1'b1;

    check("final_ops_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gemm_issue_seq.md
# gemm_issue_seq

Receive-side sequencer for GEMM instruction entries produced by the GEMM functional unit. It buffers each entry in a small FIFO, then steps it through scratchpad operand loads (weights, inputs, partial sums), a systolic-array compute, and a result writeback of the destination matrix. It sits between the GEMM functional unit and the scratchpad/systolic-array control. It is the consumer end of the GEMM instruction path.

## Interface
Parameters:
- `MAT_W`, default 4: width of a matrix register number (matches `matbits_t`).
- `DEPTH`, default 4: FIFO entries; must be a power of two and ≥ 2.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `push_valid`  in  1  GEMM FU presents an entry.
- `push_ready`  out  1  FIFO not full.
- `push_new_weight`  in  1  entry's new-weight flag.
- `push_rd`, `push_rs1`, `push_rs2`, `push_rs3`  in  MAT_W each  entry matrix numbers. Roles: rs1 = input, rs2 = weight, rs3 = partial sum.
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries.
- `sp_req_valid`  out  1  scratchpad load request.
- `sp_req_ready`  in  1  scratchpad accepts the request.
- `sp_req_kind`  out  2  request kind: 0 = weight, 1 = input, 2 = psum.
- `sp_req_mat`  out  MAT_W  matrix number to load.
- `array_start`  out  1  one-cycle compute launch.
- `array_done`  in  1  compute finished; single-cycle pulse.
- `wb_valid`  out  1  result write request.
- `wb_ready`  in  1  write accepted.
- `wb_rd`  out  MAT_W  destination matrix.
- `busy`  out  1  sequencer state not IDLE.

## Operation
FIFO:
- A push happens on `push_valid && push_ready`. It stores {new_weight, rd, rs3, rs2, rs1}.
- `push_ready = (fifo_count != DEPTH)`.
- Read and write pointers wrap modulo DEPTH.
- A simultaneous push and pop when full is not allowed, because push_ready is already low.
- A simultaneous push and pop when non-empty leaves the count unchanged.

Sequencer states: IDLE, LD_W, LD_I, LD_P, START, WAIT, WB.
- IDLE:
  - If fifo_count > 0, pop the head entry into the current-entry register.
  - Go to LD_W if the popped new_weight = 1 (or always, when the macro is absent). Otherwise go to LD_I.
  - A pop in IDLE and a push in the same cycle are both honoured.
- LD_W: `sp_req_valid=1`, kind 0, mat = rs2. Advance to LD_I on `sp_req_ready`.
- LD_I: `sp_req_valid=1`, kind 1, mat = rs1. Advance to LD_P on `sp_req_ready`.
- LD_P: `sp_req_valid=1`, kind 2, mat = rs3. Advance to START on `sp_req_ready`.
- START: `array_start=1` for exactly one cycle, then go to WAIT.
- WAIT: hold until `array_done`, then go to WB. `array_done` outside WAIT is ignored.
- WB: `wb_valid=1`, `wb_rd` = rd. Go to IDLE on `wb_ready`.

Handshake rules:
- While `sp_req_valid` or `wb_valid` is high, the associated kind/mat/rd outputs are held stable until the handshake completes.
- Only one entry is in flight at a time.

## Timing
- Reset: FIFO emptied, pointers 0, state IDLE. Outputs after reset: `fifo_count=0`, `push_ready=1`, `sp_req_valid=0`, `sp_req_kind=0`, `sp_req_mat=0`, `array_start=0`, `wb_valid=0`, `wb_rd=0`, `busy=0`.
- Reset asserted mid-operation discards the in-flight entry and all queued entries the next edge. No further request is issued.
- Push-to-visibility: an entry pushed at edge N can be popped at edge N+1.
- Pop-to-first-request: an entry popped at edge N has `sp_req_valid` high in cycle N+1.
- Minimum latency, pop to `wb_valid`, with all readies held high and `array_done` arriving one cycle after `array_start`:
  - 6 cycles with the weight load.
  - 5 cycles without it.
- Back-to-back entries: the next pop occurs on the cycle the WB handshake completes plus one (in IDLE).
- `fifo_count` and `push_ready` are registered-state derived. Neither has a combinational path from `push_valid`.

## Configuration
- `GEMM_WEIGHT_SKIP_EN` defined: LD_W is entered only when the entry's new_weight = 1. Otherwise weights already resident in the array are reused.
- `GEMM_WEIGHT_SKIP_EN` undefined: new_weight is stored but ignored, and LD_W is always performed.

## Test plan
- Reset, then push {nw=1, rd=3, rs1=1, rs2=2, rs3=4} with all readies high and `array_done` one cycle after start. Required: requests (0,2), (1,1), (2,4), one `array_start` pulse, `wb_valid` with rd=3, `busy` drops after WB.
- Push nw=0 with the macro defined: no kind-0 request; the first request is (1,rs1). Same stimulus with the macro undefined: a kind-0 request is issued first.
- Push 5 entries back-to-back while the sequencer stalls (`sp_req_ready=0`), DEPTH=4. Required: after the first pop, 4 entries are queued; `push_ready=0` and the 6th push is refused. Release the stall: entries complete in FIFO order.
- Hold `sp_req_ready=0` for 3 cycles in LD_I. Required: `sp_req_valid`, kind 1 and mat stay constant; advance only on ready.
- Pulse `array_done` while in LD_P. Required: ignored; WB is entered only after a `array_done` in WAIT.
- Assert `RST` during WAIT with 2 entries queued. Required: next cycle `busy=0`, `fifo_count=0`, no `wb_valid`.
